// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - Shared types and constants for the MEM access stage
// Contents: MEM-stage FSM state encoding, MEM/WB bank record type,
//           bubble constant, default watchdog timeout.
package cpu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        hlt;
        logic        llb;
        logic        lhb;
        logic [15:0] read_data;
        logic [15:0] alu_result;
        logic [3:0]  write_reg_addr;
    } mem_wb_t;

    // A bubble never writes the register file and never halts.
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - Data memory req/ack bus between MEM stage and memory
// Signals: mem_req, mem_we, mem_addr[15:0], mem_wdata[15:0] (stage -> memory)
//          mem_rdata[15:0], mem_ack (memory -> stage)
// Modports: master (MEM stage), slave (memory)
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - MEM/WB pipeline register bank with load-enable and bubble-select
// Ports: clk, rst_n (async active-low), load_en, bubble, d (mem_wb_t), q (mem_wb_t)
module mem_wb_pipe_reg
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load_en,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= MEM_WB_BUBBLE;
        end else if (bubble) begin
            q <= MEM_WB_BUBBLE;
        end else if (load_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data memory handshake, stall, watchdog, MEM/WB bank
// Ports: clk, rst_n (async active-low); EX_MEM_* stage inputs; mem (memory bus, master);
//        mem_stall (freeze upstream), mem_err (1-cycle error pulse); MEM_WB_* bank outputs.
// Parameters: TIMEOUT (WAIT cycles before abort, 2..255), TO_W (watchdog counter width).
// Build option: MEM_MISALIGN_CHK_EN - odd-address accesses are dropped with mem_err.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemToReg,
    input  logic        EX_MEM_RegWrite,
    input  logic [15:0] EX_MEM_ALU_Result,
    input  logic [15:0] EX_MEM_WriteData,
    input  logic [3:0]  EX_MEM_WriteRegAddr,
    input  logic        EX_MEM_hlt,
    input  logic        LLB_in,
    input  logic        LHB_in,
    mem_access_stage_if.master mem,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemToReg,
    output logic        MEM_WB_hlt,
    output logic        MEM_WB_LLB,
    output logic        MEM_WB_LHB,
    output logic [15:0] MEM_WB_ReadData,
    output logic [15:0] MEM_WB_ALU_Result,
    output logic [3:0]  MEM_WB_WriteRegAddr
);

    mem_state_t      state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;

    logic    access;
    logic    misalign;
    logic    req_access;
    logic    timeout;
    logic    done;
    logic    req_raw;
    logic    stall_raw;
    mem_wb_t wb_d, wb_q;

    assign access = EX_MEM_MemRead | EX_MEM_MemWrite;

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign = access & EX_MEM_ALU_Result[0];
`else
    assign misalign = 1'b0;
`endif

    // Only aligned accesses reach the memory; a misaligned one retires without stalling.
    assign req_access = access & ~misalign;

    assign timeout   = (state == ST_WAIT) && (to_cnt == TO_W'(TIMEOUT - 1));
    assign done      = (state == ST_WAIT) && (mem.mem_ack || timeout);
    // Combinational release lets upstream advance on the same edge the access completes.
    assign stall_raw = req_access & ~done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        req_raw    = 1'b0;
        case (state)
            ST_IDLE: begin
                // mem_ack is deliberately ignored here: a late ack after an abort must not retire anything.
                to_cnt_nxt = '0;
                if (req_access) begin
                    req_raw   = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_raw = 1'b1;
                if (done) begin
                    state_nxt  = ST_IDLE;
                    to_cnt_nxt = '0;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                to_cnt_nxt = '0;
            end
        endcase
    end

    // Reset forces every output low immediately, including the combinational ones.
    assign mem.mem_req   = rst_n & req_raw;
    assign mem.mem_we    = rst_n & EX_MEM_MemWrite;
    assign mem.mem_addr  = rst_n ? EX_MEM_ALU_Result : 16'h0000;
    assign mem.mem_wdata = rst_n ? EX_MEM_WriteData  : 16'h0000;
    assign mem_stall     = rst_n & stall_raw;
    assign mem_err       = rst_n & (timeout | misalign);

    always_comb begin
        wb_d                = MEM_WB_BUBBLE;
        wb_d.reg_write      = EX_MEM_RegWrite & ~misalign;
        wb_d.mem_to_reg     = EX_MEM_MemToReg;
        wb_d.hlt            = EX_MEM_hlt;
        wb_d.llb            = LLB_in;
        wb_d.lhb            = LHB_in;
        wb_d.alu_result     = EX_MEM_ALU_Result;
        wb_d.write_reg_addr = EX_MEM_WriteRegAddr;
        // Write wins when both are set; an abort retires with zero data.
        if ((state == ST_WAIT) && mem.mem_ack && EX_MEM_MemRead && !EX_MEM_MemWrite) begin
            wb_d.read_data = mem.mem_rdata;
        end
    end

    mem_wb_pipe_reg u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (~stall_raw),
        .bubble  (stall_raw),
        .d       (wb_d),
        .q       (wb_q)
    );

    assign MEM_WB_RegWrite     = wb_q.reg_write;
    assign MEM_WB_MemToReg     = wb_q.mem_to_reg;
    assign MEM_WB_hlt          = wb_q.hlt;
    assign MEM_WB_LLB          = wb_q.llb;
    assign MEM_WB_LHB          = wb_q.lhb;
    assign MEM_WB_ReadData     = wb_q.read_data;
    assign MEM_WB_ALU_Result   = wb_q.alu_result;
    assign MEM_WB_WriteRegAddr = wb_q.write_reg_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - Directed self-checking bench for mem_access_stage (TIMEOUT=8)
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic [15:0] alu_result, write_data;
    logic [3:0]  write_reg_addr;
    logic        hlt, llb_in, lhb_in;
    logic        mem_stall, mem_err;
    logic        wb_reg_write, wb_mem_to_reg, wb_hlt, wb_llb, wb_lhb;
    logic [15:0] wb_read_data, wb_alu_result;
    logic [3:0]  wb_write_reg_addr;

    int checks = 0;
    int errors = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(8), .TO_W(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .EX_MEM_MemRead      (mem_read),
        .EX_MEM_MemWrite     (mem_write),
        .EX_MEM_MemToReg     (mem_to_reg),
        .EX_MEM_RegWrite     (reg_write),
        .EX_MEM_ALU_Result   (alu_result),
        .EX_MEM_WriteData    (write_data),
        .EX_MEM_WriteRegAddr (write_reg_addr),
        .EX_MEM_hlt          (hlt),
        .LLB_in              (llb_in),
        .LHB_in              (lhb_in),
        .mem                 (bus),
        .mem_stall           (mem_stall),
        .mem_err             (mem_err),
        .MEM_WB_RegWrite     (wb_reg_write),
        .MEM_WB_MemToReg     (wb_mem_to_reg),
        .MEM_WB_hlt          (wb_hlt),
        .MEM_WB_LLB          (wb_llb),
        .MEM_WB_LHB          (wb_lhb),
        .MEM_WB_ReadData     (wb_read_data),
        .MEM_WB_ALU_Result   (wb_alu_result),
        .MEM_WB_WriteRegAddr (wb_write_reg_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] dst);
        mem_read       = rd;
        mem_write      = wr;
        mem_to_reg     = m2r;
        reg_write      = rw;
        alu_result     = alu;
        write_data     = wd;
        write_reg_addr = dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        hlt    = 1'b0;
        llb_in = 1'b0;
        lhb_in = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'hAAAA, 4'd5);

        // Reset state with a pending access on the inputs
        #2;
        chk("rst_req",   bus.mem_req, 1'b0);
        chk("rst_addr",  bus.mem_addr, 16'h0000);
        chk("rst_wdata", bus.mem_wdata, 16'h0000);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_err",   mem_err, 1'b0);
        chk("rst_wb_rw", wb_reg_write, 1'b0);
        chk("rst_wb_m2r", wb_mem_to_reg, 1'b0);
        mid();
        rst_n = 1'b1;
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        step();

        // Load, ack three cycles after req
        instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 4'd5);
        mid();
        chk("ld_c0_req",   bus.mem_req, 1'b1);
        chk("ld_c0_we",    bus.mem_we, 1'b0);
        chk("ld_c0_addr",  bus.mem_addr, 16'h0100);
        chk("ld_c0_stall", mem_stall, 1'b1);
        step();
        mid();
        chk("ld_c1_stall",  mem_stall, 1'b1);
        chk("ld_c1_req",    bus.mem_req, 1'b1);
        chk("ld_c1_bub_rw", wb_reg_write, 1'b0);
        chk("ld_c1_bub_m2r", wb_mem_to_reg, 1'b0);
        step();
        mid();
        chk("ld_c2_stall", mem_stall, 1'b1);
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        mid();
        chk("ld_c3_stall", mem_stall, 1'b0);
        chk("ld_c3_req",   bus.mem_req, 1'b1);
        step();

        // ADD r3 = 7, with LLB passthrough
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        instr(1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 16'h0000, 4'd3);
        llb_in = 1'b1;
        mid();
        chk("ld_wb_rdata", wb_read_data, 16'hBEEF);
        chk("ld_wb_dst",   wb_write_reg_addr, 4'd5);
        chk("ld_wb_rw",    wb_reg_write, 1'b1);
        chk("ld_wb_m2r",   wb_mem_to_reg, 1'b1);
        chk("add_req",     bus.mem_req, 1'b0);
        chk("add_stall",   mem_stall, 1'b0);
        step();

        // Store 0x1234 to 0x0040, ack in the first WAIT cycle
        llb_in = 1'b0;
        instr(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h1234, 4'd0);
        mid();
        chk("add_wb_alu",  wb_alu_result, 16'h0007);
        chk("add_wb_dst",  wb_write_reg_addr, 4'd3);
        chk("add_wb_rw",   wb_reg_write, 1'b1);
        chk("add_wb_llb",  wb_llb, 1'b1);
        chk("add_wb_rd",   wb_read_data, 16'h0000);
        chk("st_c0_req",   bus.mem_req, 1'b1);
        chk("st_c0_we",    bus.mem_we, 1'b1);
        chk("st_c0_addr",  bus.mem_addr, 16'h0040);
        chk("st_c0_wdata", bus.mem_wdata, 16'h1234);
        chk("st_c0_stall", mem_stall, 1'b1);
        step();
        bus.mem_ack = 1'b1;
        mid();
        chk("st_c1_req",   bus.mem_req, 1'b1);
        chk("st_c1_we",    bus.mem_we, 1'b1);
        chk("st_c1_addr",  bus.mem_addr, 16'h0040);
        chk("st_c1_wdata", bus.mem_wdata, 16'h1234);
        chk("st_c1_stall", mem_stall, 1'b0);
        chk("st_c1_bub_rw", wb_reg_write, 1'b0);
        chk("st_c1_bub_llb", wb_llb, 1'b0);
        step();

        // Back-to-back: load 0x0200 -> r6, then store 0x5555 to 0x0300
        bus.mem_ack = 1'b0;
        instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0000, 4'd6);
        mid();
        chk("st_wb_rw",    wb_reg_write, 1'b0);
        chk("st_wb_alu",   wb_alu_result, 16'h0040);
        chk("st_wb_rd",    wb_read_data, 16'h0000);
        chk("b2b_ld_req",  bus.mem_req, 1'b1);
        chk("b2b_ld_we",   bus.mem_we, 1'b0);
        chk("b2b_ld_addr", bus.mem_addr, 16'h0200);
        chk("b2b_ld_stall", mem_stall, 1'b1);
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1111;
        mid();
        chk("b2b_ld_done", mem_stall, 1'b0);
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        instr(1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h5555, 4'd0);
        mid();
        chk("b2b_ld_wb_rd",  wb_read_data, 16'h1111);
        chk("b2b_ld_wb_dst", wb_write_reg_addr, 4'd6);
        chk("b2b_st_req",    bus.mem_req, 1'b1);
        chk("b2b_st_we",     bus.mem_we, 1'b1);
        chk("b2b_st_addr",   bus.mem_addr, 16'h0300);
        chk("b2b_st_stall",  mem_stall, 1'b1);
        step();
        bus.mem_ack = 1'b1;
        mid();
        chk("b2b_st_done",  mem_stall, 1'b0);
        chk("b2b_st_wdata", bus.mem_wdata, 16'h5555);
        step();
        bus.mem_ack = 1'b0;
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        mid();
        chk("b2b_st_wb_alu", wb_alu_result, 16'h0300);
        chk("b2b_st_wb_rw",  wb_reg_write, 1'b0);
        chk("idle_req",      bus.mem_req, 1'b0);
        chk("idle_stall",    mem_stall, 1'b0);
        step();

        // Timeout: load 0x0400 -> r7, ack never comes
        instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0400, 16'h0000, 4'd7);
        mid();
        chk("to_c0_stall", mem_stall, 1'b1);
        chk("to_c0_err",   mem_err, 1'b0);
        for (int w = 1; w <= 7; w++) begin
            step();
            mid();
            chk($sformatf("to_w%0d_stall", w), mem_stall, 1'b1);
            chk($sformatf("to_w%0d_err", w), mem_err, 1'b0);
        end
        step();
        mid();
        chk("to_w8_err",   mem_err, 1'b1);
        chk("to_w8_stall", mem_stall, 1'b0);
        chk("to_w8_req",   bus.mem_req, 1'b1);
        step();
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        mid();
        chk("to_post_err",   mem_err, 1'b0);
        chk("to_post_req",   bus.mem_req, 1'b0);
        chk("to_wb_rd",      wb_read_data, 16'h0000);
        chk("to_wb_rw",      wb_reg_write, 1'b1);
        chk("to_wb_dst",     wb_write_reg_addr, 4'd7);
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        mid();
        chk("late_ack_rd",  wb_read_data, 16'h0000);
        chk("late_ack_req", bus.mem_req, 1'b0);
        step();

        // Odd address: load 0x0301 -> r2
        instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0301, 16'h0000, 4'd2);
`ifdef MEM_MISALIGN_CHK_EN
        mid();
        chk("mis_req",   bus.mem_req, 1'b0);
        chk("mis_stall", mem_stall, 1'b0);
        chk("mis_err",   mem_err, 1'b1);
        step();
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        mid();
        chk("mis_wb_rw", wb_reg_write, 1'b0);
        chk("mis_wb_rd", wb_read_data, 16'h0000);
        step();
`else
        mid();
        chk("odd_req",   bus.mem_req, 1'b1);
        chk("odd_addr",  bus.mem_addr, 16'h0301);
        chk("odd_err",   mem_err, 1'b0);
        chk("odd_stall", mem_stall, 1'b1);
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h00AA;
        mid();
        chk("odd_done", mem_stall, 1'b0);
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        mid();
        chk("odd_wb_rd", wb_read_data, 16'h00AA);
        chk("odd_wb_rw", wb_reg_write, 1'b1);
        step();
`endif

        // Reset in the middle of a WAIT
        instr(1'b1, 1'b1, 1'b0, 1'b0, 16'h0500, 16'h7777, 4'd8);
        mid();
        chk("rw_c0_stall", mem_stall, 1'b1);
        step();
        chk("rw_c1_req", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_req",   bus.mem_req, 1'b0);
        chk("rw_rst_we",    bus.mem_we, 1'b0);
        chk("rw_rst_addr",  bus.mem_addr, 16'h0000);
        chk("rw_rst_wdata", bus.mem_wdata, 16'h0000);
        chk("rw_rst_stall", mem_stall, 1'b0);
        chk("rw_rst_err",   mem_err, 1'b0);
        mid();
        rst_n = 1'b1;
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        #1;
        chk("rw_rel_req",   bus.mem_req, 1'b0);
        chk("rw_rel_stall", mem_stall, 1'b0);
        step();
        mid();
        chk("rw_idle_req", bus.mem_req, 1'b0);
        step();

        // Watchdog restarts from zero after reset
        instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0600, 16'h0000, 4'd9);
        mid();
        chk("rw_to_c0_stall", mem_stall, 1'b1);
        for (int w = 1; w <= 7; w++) begin
            step();
            mid();
            chk($sformatf("rw_to_w%0d_err", w), mem_err, 1'b0);
        end
        step();
        mid();
        chk("rw_to_w8_err",   mem_err, 1'b1);
        chk("rw_to_w8_stall", mem_stall, 1'b0);
        step();
        instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        mid();
        chk("rw_to_wb_dst", wb_write_reg_addr, 4'd9);
        chk("rw_to_wb_rd",  wb_read_data, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
